risc_v_mike_uart_fifo: RTL and testbench
========================================

RISC_V_MIKE_UART_FIFO -- requirements
Module: risc_v_mike_uart_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning UART character width (5..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO (power of two, >=2).
REQ-003 SHALL have parameter BAUD_DIV_RST, default 16'd433, meaning reset value of the baud divisor (bit period = DIV+1 clk cycles).
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port bus_addr, input, 4, byte offset (0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC BAUD).
REQ-008 SHALL have port bus_wr, input, 1, write strobe, one transfer per asserted cycle.
REQ-009 SHALL have port bus_rd, input, 1, read strobe, one transfer per asserted cycle.
REQ-010 SHALL have port bus_wr_data, input, 32, write data.
REQ-011 SHALL have port bus_rd_data, output, 32, combinational read data for bus_addr.
REQ-012 SHALL have port rx, input, 1, serial input, asynchronous, idle high.
REQ-013 SHALL have port tx, output, 1, serial output, idle high.
REQ-014 SHALL have port irq, output, 1, level interrupt.

Function
REQ-015 DATA write SHALL push bus_wr_data[DATA_W-1:0] into TX FIFO; push while full SHALL be dropped and not corrupt contents.
REQ-016 DATA read SHALL return RX FIFO head zero-extended in the same cycle and pop it on that clock edge; read while empty SHALL return 0 and not pop.
REQ-017 STATUS bits SHALL be: [0] rx_not_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] parity_err, [5] overrun, [6] frame_err, [7] tx_busy; others 0.
REQ-018 STATUS bits [6:4] SHALL be sticky, cleared by writing 1 to the bit; a set event in the same cycle as a clear SHALL win.
REQ-019 CTRL bits SHALL be: [0] enable, [1] parity_en, [2] parity_odd, [3] two_stop, [4] rx_ie, [5] tx_ie; reset value 0x01.
REQ-020 BAUD[15:0] SHALL be read/write; a write SHALL take effect at the next character boundary of each engine.
REQ-021 irq SHALL equal (rx_ie & rx_not_empty) | (tx_ie & tx_empty) | any sticky error bit with rx_ie.
REQ-022 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START when enable and TX FIFO not empty, popping the head on that edge.
REQ-023 TX SHALL hold each bit for exactly DIV+1 cycles, LSB first; PARITY only if parity_en (even unless parity_odd); STOP lasts 1 or 2 bit periods; STOP->START directly if FIFO not empty, else IDLE.
REQ-024 Clearing enable mid-character SHALL let TX finish the current character, then stay IDLE.
REQ-025 rx SHALL pass a 2-flop synchroniser before use.
REQ-026 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised falling edge when enable.
REQ-027 RX SHALL re-sample at (DIV+1)/2 cycles after the edge; high there SHALL return to IDLE with no error (glitch).
REQ-028 RX SHALL sample each data/parity/stop bit at DIV+1 cycle intervals thereafter; only the first stop bit is checked.
REQ-029 Stop bit low SHALL set frame_err and discard the character; parity mismatch SHALL set parity_err and discard the character.
REQ-030 Valid character with RX FIFO full SHALL set overrun and discard the new character; a same-cycle DATA-read pop SHALL make room and avoid overrun.
REQ-031 Simultaneous push and pop on a FIFO SHALL both occur with count unchanged, including when full (TX) or empty-with-bypass disallowed (pop of empty is no-op).

Reset
REQ-032 On rst: tx=1, irq=0, both FIFOs empty, FSMs IDLE, counters 0, CTRL=0x01, BAUD=BAUD_DIV_RST, sticky bits 0, synchroniser flops 1.
REQ-033 Reset asserted mid-character SHALL abort immediately; tx SHALL be 1 in the cycle rst asserts.

Structure
REQ-034 Register offsets, STATUS/CTRL bit indices and the uart state enum SHALL live in risc_v_mike_pkg.
REQ-035 FIFOs SHALL be one sub-module risc_v_mike_sync_fifo (params WIDTH, DEPTH; push, pop, full, empty, count), instantiated twice.

Verification
REQ-036 BAUD=3, write 0x55 -> tx frame 0,1,0,1,0,1,0,1,0,1 each bit 4 cycles, then tx_empty=1, tx_busy=0.
REQ-037 parity_en=1, parity_odd=0, drive rx char 0x07 with parity 1 -> RX FIFO holds 0x07; with parity 0 -> parity_err=1, FIFO empty.
REQ-038 Drive 17 characters with FIFO_DEPTH=16 and no reads -> rx_full=1, overrun=1, first 16 read back in order.
REQ-039 Write 20 bytes to TX back-to-back -> 16 accepted, continuous frames with no idle gap, tx_full deasserts after first pop.
REQ-040 rx low pulse of 1 cycle with BAUD=15 -> no character, no error; stop bit low -> frame_err=1, write STATUS 0x40 clears it.
REQ-041 Assert rst during DATA state of TX -> tx=1 immediately, tx_empty=1, CTRL=0x01 after release.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: UART register offsets, STATUS/CTRL bit indices and the TX/RX state enum
package risc_v_mike_pkg;
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_BAUD   = 4'hC;
  localparam int ST_RX_NE = 0, ST_RX_FULL = 1, ST_TX_EMPTY = 2, ST_TX_FULL = 3;
  localparam int ST_PERR = 4, ST_OVR = 5, ST_FERR = 6, ST_TX_BUSY = 7;
  localparam int CT_EN = 0, CT_PEN = 1, CT_PODD = 2, CT_TWO = 3, CT_RXIE = 4, CT_TXIE = 5;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
endpackage

// File: rtl/risc_v_mike_sync_fifo.sv
// risc_v_mike_sync_fifo: power-of-two FIFO; push/pop/wr_data in, rd_data (head)/full/empty/count out
module risc_v_mike_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign empty = r_cnt == '0;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign count = r_cnt;
  assign rd_data = r_mem[r_rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wr_data;
endmodule

// File: rtl/risc_v_mike_uart_fifo.sv
// risc_v_mike_uart_fifo: FIFO-buffered UART; bus_addr/bus_wr/bus_rd/bus_wr_data -> bus_rd_data registers, rx in, tx/irq out
module risc_v_mike_uart_fifo
  import risc_v_mike_pkg::*;
#(
  parameter int          DATA_W       = 8,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [5:0] r_ctrl;
  logic [15:0] r_baud;
  logic r_perr, r_ovr, r_ferr;
  logic w_wr_data, w_rd_data, w_wr_stat, w_wr_ctrl, w_wr_baud, w_unused;
  logic [DATA_W-1:0] w_tx_head, w_rx_head;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CW-1:0] w_tx_cnt, w_rx_cnt;
  logic [7:0] w_status;
  uart_state_e r_tx_st, r_rx_st;
  logic [15:0] r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
  logic [2:0] r_tx_bit, r_rx_bit;
  logic [DATA_W-1:0] r_tx_sh, r_rx_sh;
  logic r_tx_par, r_tx_stop2, r_rx_par;
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  logic w_tx_tick, w_tx_load, w_rx_samp, w_rx_fall, w_rx_done;
  logic w_rx_ferr, w_rx_perr, w_rx_ok, w_rx_ovr;
  logic [15:0] w_rx_half;
  assign w_wr_data = bus_wr & (bus_addr == ADDR_DATA);
  assign w_rd_data = bus_rd & (bus_addr == ADDR_DATA);
  assign w_wr_stat = bus_wr & (bus_addr == ADDR_STATUS);
  assign w_wr_ctrl = bus_wr & (bus_addr == ADDR_CTRL);
  assign w_wr_baud = bus_wr & (bus_addr == ADDR_BAUD);
  assign w_unused = ^bus_wr_data[31:16];
  risc_v_mike_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_wr_data), .pop(w_tx_load), .wr_data(bus_wr_data[DATA_W-1:0]),
    .rd_data(w_tx_head), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_cnt));
  risc_v_mike_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_ok), .pop(w_rd_data), .wr_data(r_rx_sh),
    .rd_data(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_cnt));
  assign w_status = {r_tx_st != S_IDLE, r_ferr, r_ovr, r_perr, w_tx_full, w_tx_cnt == '0, w_rx_full, w_rx_cnt != '0};
  assign bus_rd_data = bus_addr == ADDR_DATA   ? (w_rx_empty ? '0 : 32'(w_rx_head)) :
                       bus_addr == ADDR_STATUS ? 32'(w_status) :
                       bus_addr == ADDR_CTRL   ? 32'(r_ctrl) :
                       bus_addr == ADDR_BAUD   ? 32'(r_baud) : '0;
  assign irq = (r_ctrl[CT_RXIE] & (~w_rx_empty | r_perr | r_ovr | r_ferr)) | (r_ctrl[CT_TXIE] & w_tx_empty);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ctrl <= 6'h01;
      r_baud <= BAUD_DIV_RST;
      r_perr <= 1'b0;
      r_ovr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus_wr_data[5:0];
      if (w_wr_baud) r_baud <= bus_wr_data[15:0];
      r_perr <= w_rx_perr | (r_perr & ~(w_wr_stat & bus_wr_data[ST_PERR]));
      r_ovr <= w_rx_ovr | (r_ovr & ~(w_wr_stat & bus_wr_data[ST_OVR]));
      r_ferr <= w_rx_ferr | (r_ferr & ~(w_wr_stat & bus_wr_data[ST_FERR]));
    end
  // Divisor is latched per character so a BAUD write only applies at the next start bit.
  assign w_tx_tick = r_tx_cnt == r_tx_div;
  assign w_tx_load = r_ctrl[CT_EN] & ~w_tx_empty &
                     ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_tick & (~r_ctrl[CT_TWO] | r_tx_stop2)));
  assign tx = r_tx_st == S_START ? 1'b0 : r_tx_st == S_DATA ? r_tx_sh[0] : r_tx_st == S_PARITY ? r_tx_par : 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_st <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_div <= '0;
      r_tx_bit <= '0;
      r_tx_sh <= '0;
      r_tx_par <= 1'b0;
      r_tx_stop2 <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_st <= S_START;
      r_tx_cnt <= '0;
      r_tx_div <= r_baud;
      r_tx_sh <= w_tx_head;
      r_tx_par <= ^w_tx_head ^ r_ctrl[CT_PODD];
      r_tx_stop2 <= 1'b0;
    end else if (r_tx_st != S_IDLE) begin
      r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + 16'd1;
      if (w_tx_tick)
        case (r_tx_st)
          S_START: begin
            r_tx_st <= S_DATA;
            r_tx_bit <= '0;
          end
          S_DATA: begin
            r_tx_sh <= r_tx_sh >> 1;
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'(DATA_W-1)) r_tx_st <= r_ctrl[CT_PEN] ? S_PARITY : S_STOP;
          end
          S_PARITY: r_tx_st <= S_STOP;
          default: begin
            r_tx_stop2 <= 1'b1;
            if (~r_ctrl[CT_TWO] | r_tx_stop2) r_tx_st <= S_IDLE;
          end
        endcase
    end
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_half = 16'((17'(r_rx_div) + 17'd1) >> 1);
  assign w_rx_samp = r_rx_cnt == (r_rx_st == S_START ? w_rx_half : r_rx_div);
  assign w_rx_done = (r_rx_st == S_STOP) & w_rx_samp;
  assign w_rx_ferr = w_rx_done & ~r_rx_s2;
  assign w_rx_perr = w_rx_done & r_rx_s2 & r_ctrl[CT_PEN] & (r_rx_par != (^r_rx_sh ^ r_ctrl[CT_PODD]));
  assign w_rx_ok = w_rx_done & r_rx_s2 & ~w_rx_perr;
  // A DATA read in the same cycle frees a slot, so only a genuinely full FIFO overruns.
  assign w_rx_ovr = w_rx_ok & w_rx_full & ~w_rd_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_div <= '0;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
      r_rx_par <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (r_rx_st == S_IDLE) begin
        if (r_ctrl[CT_EN] & w_rx_fall) begin
          r_rx_st <= S_START;
          r_rx_cnt <= '0;
          r_rx_div <= r_baud;
        end
      end else begin
        r_rx_cnt <= w_rx_samp ? '0 : r_rx_cnt + 16'd1;
        if (w_rx_samp)
          case (r_rx_st)
            S_START: begin
              r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
              r_rx_bit <= '0;
            end
            S_DATA: begin
              r_rx_sh <= {r_rx_s2, r_rx_sh[DATA_W-1:1]};
              r_rx_bit <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'(DATA_W-1)) r_rx_st <= r_ctrl[CT_PEN] ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
              r_rx_par <= r_rx_s2;
              r_rx_st <= S_STOP;
            end
            default: r_rx_st <= S_IDLE;
          endcase
      end
    end
endmodule

// File: tb/tb_risc_v_mike_uart_fifo.sv
// tb_risc_v_mike_uart_fifo: scoreboard bench for the FIFO-buffered UART
module tb_risc_v_mike_uart_fifo;
  import risc_v_mike_pkg::*;
  logic clk = 0, rst = 1, bus_wr = 0, bus_rd = 0, rx = 1;
  logic [3:0] bus_addr = '0;
  logic [31:0] bus_wr_data = '0;
  logic [31:0] bus_rd_data;
  logic tx, irq;
  int checks = 0, errors = 0, cyc = 0;
  int rx_d = 8;
  int tx_d = 4;
  logic [7:0] exp_rx[$], exp_tx[$];

  risc_v_mike_uart_fifo dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .rx(rx), .tx(tx), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wr_data = d; bus_wr = 1;
    @(posedge clk); #1 bus_wr = 0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; #1 d = bus_rd_data;
  endtask

  task automatic pop_rx(output logic [31:0] d);
    bus_addr = ADDR_DATA; bus_rd = 1; #1 d = bus_rd_data;
    @(posedge clk); #1 bus_rd = 0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b; repeat (n) @(posedge clk); #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par, input logic stop, input logic ok);
    drive_bit(1'b0, rx_d);
    for (int i = 0; i < 8; i++) drive_bit(d[i], rx_d);
    if (par_en) drive_bit(par, rx_d);
    drive_bit(stop, rx_d);
    if (ok) exp_rx.push_back(d);
    drive_bit(1'b1, 2 * rx_d);
  endtask

  task automatic wait_tx_low(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = (tx === 1'b0);
    end
  endtask

  task automatic capture_tx(output logic [7:0] d, output bit good);
    repeat (tx_d / 2) @(negedge clk);
    good = (tx === 1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (tx_d) @(negedge clk);
      d[b] = tx;
    end
    repeat (tx_d) @(negedge clk);
    good = good && (tx === 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1; repeat (3) @(posedge clk); #1 rst = 0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL reset_status got %h exp 04", v); end
    peek(ADDR_CTRL, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL reset_ctrl got %h exp 01", v); end
    peek(ADDR_BAUD, v);
    checks++; if (v !== 32'd433) begin errors++; $display("FAIL reset_baud got %0d exp 433", v); end
    peek(ADDR_DATA, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", v); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] f;
    logic [7:0] got, e;
    logic [31:0] v;
    bit ok;
    int bad;
    wr(ADDR_BAUD, 32'd3);
    tx_d = 4;
    wr(ADDR_DATA, 32'h55);
    exp_tx.push_back(8'h55);
    f = {1'b1, 8'h55, 1'b0};
    wait_tx_low(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_start_timeout got none exp start bit"); end
    bad = 0; got = '0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (tx !== f[k/4]) bad++;
      if (k % 4 == 2 && k / 4 >= 1 && k / 4 <= 8) got[k/4-1] = tx;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_bit_timing got %0d bad cycles exp 0", bad); end
    e = exp_tx.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL tx_frame_data got %h exp %h", got, e); end
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after got %b exp 1", tx); end
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL tx_done_status got %h exp 04", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0] got, e;
    bit ok, good;
    int t, tp;
    wr(ADDR_CTRL, 32'h00);
    for (int i = 0; i < 20; i++) begin
      wr(ADDR_DATA, 32'h30 + i);
      if (i < 16) exp_tx.push_back(8'(8'h30 + i));
    end
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h08) begin errors++; $display("FAIL b2b_full_status got %h exp 08", v); end
    wr(ADDR_CTRL, 32'h01);
    @(posedge clk); #1;
    peek(ADDR_STATUS, v);
    checks++; if (v[ST_TX_FULL] !== 1'b0) begin errors++; $display("FAIL b2b_full_after_pop got %b exp 0", v[ST_TX_FULL]); end
    tp = 0;
    for (int n = 0; n < 16; n++) begin
      wait_tx_low(tx_d * 12, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_frame_timeout got none exp frame %0d", n); break; end
      t = cyc;
      if (n > 0) begin
        checks++; if (t - tp != 10 * tx_d) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", t - tp, 10 * tx_d); end
      end
      tp = t;
      capture_tx(got, good);
      e = exp_tx.pop_front();
      if (!good || got !== e) begin errors++; $display("FAIL b2b_data got %h framing %0d exp %h", got, good, e); end
    end
    wait_tx_low(60, ok);
    checks++; if (ok) begin errors++; $display("FAIL b2b_extra_frame got frame exp idle"); end
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL b2b_end_status got %h exp 04", v); end
  endtask

  task automatic test_rx_parity;
    logic [31:0] v;
    logic [7:0] e;
    wr(ADDR_BAUD, 32'd7);
    rx_d = 8;
    wr(ADDR_CTRL, 32'h03);
    send_rx(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h05) begin errors++; $display("FAIL par_good_status got %h exp 05", v); end
    pop_rx(v);
    e = exp_rx.pop_front();
    checks++; if (v !== 32'(e)) begin errors++; $display("FAIL par_good_data got %h exp %h", v, e); end
    send_rx(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h14) begin errors++; $display("FAIL par_err_status got %h exp 14", v); end
    wr(ADDR_STATUS, 32'h10);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL par_clear_status got %h exp 04", v); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] v;
    logic [7:0] e;
    wr(ADDR_CTRL, 32'h01);
    for (int i = 0; i < 17; i++) send_rx(8'(8'hA0 + i), 1'b0, 1'b0, 1'b1, i < 16);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h27) begin errors++; $display("FAIL ovr_status got %h exp 27", v); end
    for (int i = 0; i < 16; i++) begin
      pop_rx(v);
      checks++;
      if (exp_rx.size() == 0) begin errors++; $display("FAIL ovr_scoreboard got %h exp nothing", v); end
      else begin
        e = exp_rx.pop_front();
        if (v !== 32'(e)) begin errors++; $display("FAIL ovr_data got %h exp %h", v, e); end
      end
    end
    pop_rx(v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovr_empty_read got %h exp 0", v); end
    wr(ADDR_STATUS, 32'h20);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL ovr_clear got %h exp 04", v); end
  endtask

  task automatic test_glitch_frame;
    logic [31:0] v;
    wr(ADDR_BAUD, 32'd15);
    rx_d = 16;
    rx = 0; @(posedge clk); #1 rx = 1;
    repeat (60) @(posedge clk); #1;
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL glitch_status got %h exp 04", v); end
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h44) begin errors++; $display("FAIL frame_err_status got %h exp 44", v); end
    wr(ADDR_STATUS, 32'h40);
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL frame_err_clear got %h exp 04", v); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    logic [7:0] e;
    wr(ADDR_CTRL, 32'h21);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got %b exp 1", irq); end
    wr(ADDR_CTRL, 32'h11);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_quiet got %b exp 0", irq); end
    send_rx(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx got %b exp 1", irq); end
    pop_rx(v);
    e = exp_rx.pop_front();
    checks++; if (v !== 32'(e)) begin errors++; $display("FAIL irq_rx_data got %h exp %h", v, e); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop got %b exp 0", irq); end
    send_rx(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_ferr got %b exp 1", irq); end
    wr(ADDR_STATUS, 32'h40);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ferr_clear got %b exp 0", irq); end
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] v;
    bit ok;
    wr(ADDR_BAUD, 32'd3);
    tx_d = 4;
    wr(ADDR_CTRL, 32'h01);
    wr(ADDR_DATA, 32'h00);
    wait_tx_low(20, ok);
    repeat (8) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midtx_data_bit got %b exp 0", tx); end
    #2 rst = 1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midtx_rst_tx got %b exp 1", tx); end
    @(posedge clk); #1 rst = 0;
    peek(ADDR_STATUS, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL midtx_status got %h exp 04", v); end
    peek(ADDR_CTRL, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL midtx_ctrl got %h exp 01", v); end
    peek(ADDR_BAUD, v);
    checks++; if (v !== 32'd433) begin errors++; $display("FAIL midtx_baud got %0d exp 433", v); end
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_tx_frame;
    test_back_to_back;
    test_rx_parity;
    test_rx_overrun;
    test_glitch_frame;
    test_irq;
    test_reset_mid_tx;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
